// File: rtl/spi_master_multi.sv
// SPI master: runtime packet length, all four CPOL/CPHA modes, addressable chip selects.
// Each accepted recv word runs one full-duplex transfer; the captured word returns on send.
module spi_master_multi #(
    parameter int nbits       = 34,
    parameter int ncs         = 2,
    parameter int half_period = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     packet_size_ifc_val,
    output logic                     packet_size_ifc_rdy,
    input  logic [$clog2(nbits)-1:0] packet_size_ifc_msg,
    input  logic                     mode_ifc_val,
    output logic                     mode_ifc_rdy,
    input  logic [$clog2(ncs)+1:0]   mode_ifc_msg,
    input  logic                     recv_val,
    output logic                     recv_rdy,
    input  logic [nbits-1:0]         recv_msg,
    output logic                     send_val,
    input  logic                     send_rdy,
    output logic [nbits-1:0]         send_msg,
    output logic [ncs-1:0]           cs,
    output logic                     sclk,
    output logic                     mosi,
    input  logic                     miso
);
    localparam int CAW = $clog2(ncs);
    localparam int LW  = $clog2(nbits + 1);
    localparam int HW  = (half_period > 1) ? $clog2(half_period) : 1;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_DONE} state_t;

    state_t           r_state;
    logic [LW-1:0]    r_len;
    logic [CAW-1:0]   r_cs_addr;
    logic             r_cpol;
    logic             r_cpha;
    logic [nbits-1:0] r_tx;
    logic [nbits-1:0] r_rx;
    logic [HW-1:0]    r_hcnt;
    logic [LW:0]      r_edge;
    logic [ncs-1:0]   r_cs;
    logic             r_sclk;
    logic             r_send_val;

    logic [31:0]      w_ps_ext;
    logic [LW-1:0]    w_len_dec;
    logic [LW-1:0]    w_pad;
    logic [LW:0]      w_last_edge;
    logic             w_hp_end;
    logic             w_leading;
    logic             w_cfg_pend;
    logic             w_recv_fire;
    logic [ncs-1:0]   w_cs_on;

    // A length of zero or anything beyond nbits selects the full word.
    assign w_ps_ext    = 32'(packet_size_ifc_msg);
    assign w_len_dec   = (w_ps_ext == 0 || w_ps_ext > nbits) ? LW'(nbits) : LW'(w_ps_ext);
    assign w_pad       = LW'(nbits) - r_len;
    assign w_last_edge = {r_len, 1'b0} - 1'b1;
    assign w_hp_end    = (r_hcnt == HW'(half_period - 1));
    assign w_leading   = ~r_edge[0];

    assign w_cfg_pend          = packet_size_ifc_val | mode_ifc_val;
    assign packet_size_ifc_rdy = (r_state == S_IDLE);
    assign mode_ifc_rdy        = (r_state == S_IDLE);
    assign recv_rdy            = (r_state == S_IDLE) && !w_cfg_pend;
    assign w_recv_fire         = recv_val && recv_rdy;

    // An out-of-range address matches no line, so no chip select asserts.
    generate
        for (genvar gi = 0; gi < ncs; gi++) begin : g_cs
            assign w_cs_on[gi] = (r_cs_addr == CAW'(gi)) ? 1'b0 : 1'b1;
        end
    endgenerate

    assign send_val = r_send_val;
    assign send_msg = r_rx;
    assign cs       = r_cs;
    assign sclk     = r_sclk;
    assign mosi     = r_tx[nbits-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_len      <= LW'(nbits);
            r_cs_addr  <= '0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_hcnt     <= '0;
            r_edge     <= '0;
            r_cs       <= '1;
            r_sclk     <= 1'b0;
            r_send_val <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Follow a new CPOL at once so sclk never moves together with cs.
                    r_sclk <= mode_ifc_val ? mode_ifc_msg[1] : r_cpol;
                    if (packet_size_ifc_val) begin
                        r_len <= w_len_dec;
                    end
                    if (mode_ifc_val) begin
                        {r_cs_addr, r_cpol, r_cpha} <= mode_ifc_msg;
                    end
                    if (w_recv_fire) begin
                        r_tx    <= recv_msg << w_pad;
                        r_rx    <= '0;
                        r_hcnt  <= '0;
                        r_edge  <= '0;
                        r_cs    <= w_cs_on;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_hp_end) begin
                        r_hcnt  <= '0;
                        r_state <= S_XFER;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                S_XFER: begin
                    if (w_hp_end) begin
                        r_hcnt <= '0;
                        r_sclk <= ~r_sclk;
                        // Sample edge is leading for CPHA=0 and trailing for CPHA=1.
                        if (w_leading ^ r_cpha) begin
                            r_rx <= {r_rx[nbits-2:0], miso};
                        end else if (r_cpha ? (r_edge != '0) : (r_edge != w_last_edge)) begin
                            r_tx <= r_tx << 1;
                        end
                        if (r_edge == w_last_edge) begin
                            r_edge  <= '0;
                            r_state <= S_HOLD;
                        end else begin
                            r_edge <= r_edge + 1'b1;
                        end
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (w_hp_end) begin
                        r_hcnt     <= '0;
                        r_cs       <= '1;
                        r_send_val <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_hcnt <= r_hcnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (send_rdy) begin
                        r_send_val <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_multi.sv
// Scoreboard bench for spi_master_multi: a behavioural SPI slave plus a word-level model
// predicts the returned word, the bits the slave receives, the latency and chip-select timing.
module tb_spi_master_multi;
    localparam int NB  = 34;
    localparam int NCS = 2;
    localparam int HP  = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            packet_size_ifc_val = 1'b0;
    logic            packet_size_ifc_rdy;
    logic [5:0]      packet_size_ifc_msg = '0;
    logic            mode_ifc_val = 1'b0;
    logic            mode_ifc_rdy;
    logic [2:0]      mode_ifc_msg = '0;
    logic            recv_val = 1'b0;
    logic            recv_rdy;
    logic [NB-1:0]   recv_msg = '0;
    logic            send_val;
    logic            send_rdy = 1'b0;
    logic [NB-1:0]   send_msg;
    logic [NCS-1:0]  cs;
    logic            sclk;
    logic            mosi;
    logic            miso;

    always #5 clk = ~clk;

    spi_master_multi #(.nbits(NB), .ncs(NCS), .half_period(HP)) dut (
        .clk(clk), .reset(reset),
        .packet_size_ifc_val(packet_size_ifc_val), .packet_size_ifc_rdy(packet_size_ifc_rdy),
        .packet_size_ifc_msg(packet_size_ifc_msg),
        .mode_ifc_val(mode_ifc_val), .mode_ifc_rdy(mode_ifc_rdy), .mode_ifc_msg(mode_ifc_msg),
        .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
        .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
        .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_txn   = 0;
    bit hold_rdy = 1'b0;

    // Word-level model of the configuration registers.
    int m_len  = NB;
    bit m_cpol = 1'b0;
    bit m_cpha = 1'b0;
    int m_addr = 0;

    typedef struct {
        logic [NB-1:0]  send;
        logic [NB-1:0]  slave;
        int             lat;
        int             cslow;
        int             edges;
        logic [NCS-1:0] cspat;
        bit             cpol;
        int             n;
    } exp_t;
    exp_t sbq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural SPI slave: drives its response MSB first and records what it hears on mosi.
    logic [NB-1:0] sl_resp = '0;
    bit            sl_loop = 1'b0;
    logic          sl_miso = 1'b0;
    logic [NB-1:0] sl_rx   = '0;
    int            sl_nd   = 0;
    int            sl_edges = 0;
    bit            sl_act  = 1'b0;

    assign miso = sl_loop ? mosi : sl_miso;

    always @(cs) begin
        if (cs != '1 && !sl_act) begin
            sl_act   = 1'b1;
            sl_rx    = '0;
            sl_nd    = 0;
            sl_edges = 0;
            if (!m_cpha) begin
                sl_miso = sl_resp[m_len-1];
                sl_nd   = 1;
            end
        end else if (cs == '1) begin
            sl_act = 1'b0;
        end
    end

    always @(sclk) begin
        if (sl_act) begin
            sl_edges++;
            if ((sclk != m_cpol) == (m_cpha == 1'b0)) begin
                sl_rx = {sl_rx[NB-2:0], mosi};
            end else if (sl_nd < m_len) begin
                sl_miso = sl_resp[m_len-1-sl_nd];
                sl_nd++;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            send_rdy = hold_rdy ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares each presented response against the head of the scoreboard.
    initial begin
        bit             prev_val = 1'b0;
        logic [NB-1:0]  held = '0;
        int             cslow = 0;
        logic [NCS-1:0] cs_seen = '1;
        exp_t           e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                cslow    = 0;
                prev_val = 1'b0;
                cs_seen  = '1;
            end else begin
                if (cs != '1) begin
                    cslow++;
                    cs_seen = cs;
                end
                if (send_val && !prev_val) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_send_val", 64'(send_val), 64'd0);
                    end else begin
                        e = sbq[0];
                        n_txn++;
                        $display("[TB] txn %0d: N=%0d sent_to_slave=%h returned=%h", n_txn, e.n, sl_rx, send_msg);
                        chk("send_msg", 64'(send_msg), 64'(e.send));
                        chk("slave_rx_bits", 64'(sl_rx), 64'(e.slave));
                        chk("latency_cycle", 64'(cyc), 64'(e.lat));
                        chk("cs_low_cycles", 64'(cslow), 64'(e.cslow));
                        chk("sclk_edges", 64'(sl_edges), 64'(e.edges));
                        chk("cs_pattern", 64'(cs_seen), 64'(e.cspat));
                        chk("cs_released", 64'(cs), 64'({NCS{1'b1}}));
                        chk("sclk_idle", 64'(sclk), 64'(e.cpol));
                    end
                    held  = send_msg;
                    cslow = 0;
                end else if (send_val) begin
                    chk("send_msg_stable", 64'(send_msg), 64'(held));
                    chk("recv_rdy_in_done", 64'(recv_rdy), 64'd0);
                end
                if (send_val && send_rdy && sbq.size() > 0) begin
                    void'(sbq.pop_front());
                end
                prev_val = send_val;
            end
        end
    end

    task automatic do_cfg(input bit do_ps, input int ps, input bit do_mode, input logic [2:0] mode);
        int c = 0;
        @(posedge clk);
        #1;
        packet_size_ifc_val = do_ps;
        packet_size_ifc_msg = 6'(ps);
        mode_ifc_val        = do_mode;
        mode_ifc_msg        = mode;
        @(negedge clk);
        while (!packet_size_ifc_rdy && c < 400) begin
            @(negedge clk);
            c++;
        end
        chk("cfg_rdy", 64'(packet_size_ifc_rdy), 64'd1);
        chk("recv_rdy_cfg_pending", 64'(recv_rdy), 64'd0);
        @(posedge clk);
        #1;
        packet_size_ifc_val = 1'b0;
        mode_ifc_val        = 1'b0;
        if (do_ps) m_len = (ps == 0 || ps > NB) ? NB : ps;
        if (do_mode) begin
            m_addr = int'(mode[2]);
            m_cpol = mode[1];
            m_cpha = mode[0];
        end
    endtask

    task automatic do_word(input logic [NB-1:0] msg, input logic [NB-1:0] resp, input bit loop);
        exp_t          e;
        logic [NB-1:0] mask;
        int            c = 0;
        mask    = '1;
        mask    = mask >> (NB - m_len);
        sl_resp = resp;
        sl_loop = loop;
        e.send  = loop ? (msg & mask) : (resp & mask);
        e.slave = msg & mask;
        e.cslow = HP * (2 * m_len + 2);
        e.edges = 2 * m_len;
        e.cpol  = m_cpol;
        e.cspat = ~(NCS'(1) << m_addr);
        e.n     = m_len;
        @(posedge clk);
        #1;
        recv_msg = msg;
        recv_val = 1'b1;
        @(negedge clk);
        while (!recv_rdy && c < 400) begin
            @(negedge clk);
            c++;
        end
        if (!recv_rdy) begin
            chk("recv_handshake_timeout", 64'(recv_rdy), 64'd1);
            recv_val = 1'b0;
        end else begin
            e.lat = cyc + HP * (2 * m_len + 2) + 1;
            sbq.push_back(e);
            @(posedge clk);
            #1;
            recv_val = 1'b0;
        end
    endtask

    task automatic wait_done();
        int c = 0;
        while (sbq.size() != 0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        if (sbq.size() != 0) begin
            chk("done_timeout", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
    endtask

    initial begin
        int            c;
        logic [NB-1:0] r_msg;
        logic [NB-1:0] r_resp;
        logic [2:0]    md;

        #12;
        chk("reset_cs", 64'(cs), 64'({NCS{1'b1}}));
        chk("reset_sclk", 64'(sclk), 64'd0);
        chk("reset_mosi", 64'(mosi), 64'd0);
        chk("reset_send_val", 64'(send_val), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("post_reset_recv_rdy", 64'(recv_rdy), 64'd1);
        chk("post_reset_ps_rdy", 64'(packet_size_ifc_rdy), 64'd1);
        chk("post_reset_mode_rdy", 64'(mode_ifc_rdy), 64'd1);

        // Default config, miso looped back to mosi.
        do_word(34'h2_A5A5_A5A5, '0, 1'b1);
        wait_done();

        // Eight-bit packet on cs[1], CPOL=1 CPHA=1, miso held high.
        do_cfg(1'b1, 8, 1'b1, 3'b111);
        @(negedge clk);
        chk("sclk_idle_high", 64'(sclk), 64'd1);
        do_word(34'h0_00FF_FF3C, '1, 1'b0);
        wait_done();

        // All four modes with a four-bit packet.
        do_cfg(1'b1, 4, 1'b0, 3'b000);
        for (int m = 0; m < 4; m++) begin
            md = 3'(m);
            do_cfg(1'b0, 0, 1'b1, {1'b0, md[1:0]});
            do_word(34'h9, 34'h6, 1'b0);
            wait_done();
        end

        // Config and data offered together: config wins.
        @(posedge clk);
        #1;
        mode_ifc_val = 1'b1;
        mode_ifc_msg = 3'b010;
        recv_val     = 1'b1;
        recv_msg     = 34'h5;
        @(negedge clk);
        chk("recv_rdy_vs_cfg", 64'(recv_rdy), 64'd0);
        chk("mode_rdy_vs_recv", 64'(mode_ifc_rdy), 64'd1);
        @(posedge clk);
        #1;
        mode_ifc_val = 1'b0;
        recv_val     = 1'b0;
        m_addr = 0;
        m_cpol = 1'b1;
        m_cpha = 1'b0;
        do_word(34'h5, 34'hA, 1'b0);
        wait_done();

        // Back-pressure on send for ten cycles.
        hold_rdy = 1'b1;
        do_word(34'h3, 34'hC, 1'b0);
        c = 0;
        while (!send_val && c < 400) begin
            @(negedge clk);
            c++;
        end
        repeat (10) @(negedge clk);
        chk("send_val_held", 64'(send_val), 64'd1);
        chk("mode_rdy_busy", 64'(mode_ifc_rdy), 64'd0);
        hold_rdy = 1'b0;
        wait_done();

        // Packet size 0 means a full-width transfer.
        do_cfg(1'b1, 0, 1'b1, 3'b000);
        do_word(NB'({$urandom(), $urandom()}), NB'({$urandom(), $urandom()}), 1'b0);
        wait_done();

        // Randomised configurations and data.
        for (int i = 0; i < 8; i++) begin
            do_cfg(1'b1, $urandom_range(0, 63), 1'b1, 3'($urandom_range(0, 7)));
            r_msg  = NB'({$urandom(), $urandom()});
            r_resp = NB'({$urandom(), $urandom()});
            do_word(r_msg, r_resp, 1'($urandom_range(0, 1)));
            wait_done();
        end

        // Reset in the middle of the transfer, during bit 5.
        do_cfg(1'b1, 0, 1'b1, 3'b000);
        do_word(34'h1_2345_6789, 34'h3_0F0F_0F0F, 1'b0);
        repeat (24) @(posedge clk);
        #3;
        chk("pre_reset_cs", 64'(cs), 64'b10);
        chk("pre_reset_sclk", 64'(sclk), 64'd1);
        reset = 1'b0;
        #1;
        chk("async_reset_cs", 64'(cs), 64'({NCS{1'b1}}));
        chk("async_reset_sclk", 64'(sclk), 64'd0);
        sbq.delete();
        m_len  = NB;
        m_cpol = 1'b0;
        m_cpha = 1'b0;
        m_addr = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (200) @(negedge clk);
        chk("no_send_after_abort", 64'(send_val), 64'd0);
        do_word(34'h2_DEAD_BEEF, 34'h1_CAFE_F00D, 1'b0);
        wait_done();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
- Parametrised SPI master. Replaces the fixed-mode single-slave controller.
- Adds runtime packet length, all four SPI modes (CPOL/CPHA), ncs addressable chip selects, and a parametrised SCLK divider.
- Sits between a val/rdy word producer/consumer and the off-chip SPI pins.
- Each accepted word runs one full-duplex transaction. The word received from the slave is returned on the send interface.

Parameters:
- nbits, 34: maximum packet length in bits and the width of the data words.
- ncs, 2: number of chip-select lines.
- half_period, 2: SCLK half-period in clk cycles (>=1).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- packet_size_ifc_val  in  1  packet-size config valid.
- packet_size_ifc_rdy  out  1  packet-size config ready.
- packet_size_ifc_msg  in  $clog2(nbits)  packet length. 0 or any value >nbits means nbits.
- mode_ifc_val  in  1  mode config valid.
- mode_ifc_rdy  out  1  mode config ready.
- mode_ifc_msg  in  $clog2(ncs)+2  {cs_addr, cpol, cpha}.
- recv_val  in  1  transmit word valid.
- recv_rdy  out  1  transmit word ready.
- recv_msg  in  nbits  word to send, right-aligned; bit N-1 goes out first.
- send_val  out  1  received word valid.
- send_rdy  in  1  received word ready.
- send_msg  out  nbits  received word, right-aligned, zero-extended.
- cs  out  ncs  active-low chip selects.
- sclk  out  1  SPI clock.
- mosi  out  1  master out.
- miso  in  1  master in.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE.
  - Config registers: N=nbits, cpol=0, cpha=0, cs_addr=0.
  - Outputs: cs all 1, sclk=0, mosi=0, send_val=0, shift registers 0, counters 0.
  - After release: recv_rdy, packet_size_ifc_rdy and mode_ifc_rdy are all 1.
- Config handshake:
  - Both config ready signals are 1 only in IDLE.
  - Registers update on val&rdy.
  - In IDLE, if either config val is 1, recv_rdy=0 that cycle. Config takes priority over data.
- States: IDLE -> SETUP -> XFER -> HOLD -> DONE -> IDLE.
- IDLE:
  - recv_rdy=1 unless a config val is pending.
  - On recv_val&recv_rdy: load tx shift register with recv_msg << (nbits-N), clear rx shift register, go to SETUP.
- SETUP (half_period cycles):
  - cs[cs_addr]=0 (no line asserts if cs_addr>=ncs); sclk=cpol.
  - mosi = tx[nbits-1] is valid from the first SETUP cycle.
- XFER (2*N*half_period cycles):
  - sclk toggles at the end of every half-period.
  - cpha=0: sample miso into rx LSB on leading edges; shift tx left on trailing edges, except after the final bit.
  - cpha=1: shift tx left on leading edges, except the first; sample on trailing edges.
  - An edge counter terminates after 2N edges; sclk is back at cpol.
- HOLD (half_period cycles): cs still asserted, sclk=cpol.
- DONE:
  - All cs=1. send_val=1, send_msg=rx (upper nbits-N bits are 0).
  - Hold until send_rdy; then go to IDLE. send_msg stays stable while send_val=1.
- Latency: send_val rises half_period*(2N+2)+1 cycles after the recv handshake cycle.
- Config in other states: ignored (rdy=0).
- Back-to-back transactions: allowed from the IDLE cycle following DONE.
- Reset mid-transaction: immediate return to reset values, cs released, no send_val for the aborted word.

Test Plan:
1. Default config (N=34, mode 0, half_period=2), recv_msg=34'h2_A5A5_A5A5, miso looped to mosi:
   - cs[0] low for 140 cycles.
   - send_val at cycle 141 after the handshake.
   - send_msg=34'h2_A5A5_A5A5.
2. Packet size 8, mode {cs_addr=1, cpol=1, cpha=1}, recv_msg=0xFF_FF3C, miso tied to 1:
   - mosi bits 0,0,1,1,1,1,0,0.
   - cs[1] toggles, cs[0] stays 1; sclk idles high; 8 falling-then-rising edge pairs.
   - send_msg=0x0000_00FF.
3. All four modes with N=4, tx=4'b1001, slave model returning 4'b0110:
   - Sampling and shifting occur on the correct edge for each mode.
   - send_msg=4'b0110 in every mode.
4. Handshakes:
   - Config val and recv_val together in IDLE -> recv_rdy=0, config accepted first.
   - send_rdy held 0 for 10 cycles -> send_val and send_msg stable, recv_rdy stays 0.
5. Packet size 0 -> transfers 34 bits.
6. Mid-XFER (bit 5), reset=0 for one cycle:
   - cs all 1 and sclk=0 immediately, without waiting for a clock edge.
   - No send_val follows.
   - The next transaction completes normally.
